bp_arbiter: RTL

//  Shares one BytePipe register target (USB-side register map) between two BytePipe hosts,
//  e.g. USB and a debug UART. Arbitrates at whole-transaction granularity and forwards

---
 rtl/bp_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bp_arbiter.sv
// Two-host BytePipe arbiter: shares one register target between host0 and host1 per transaction.
// Latency: one cycle from host valid in IDLE to grant, then zero-latency pass-through.
// Backpressure: target ready goes to the owner, owner response ready goes to the target; nothing is buffered.
module bp_arbiter #(
  parameter logic [6:0] BURST_ADDR = 7'd0,
  parameter bit         FAIR       = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cg,
  input  logic [7:0] i_h0_data,
  input  logic       i_h0_valid,
  output logic       o_h0_ready,
  output logic [7:0] o_h0_data,
  output logic       o_h0_valid,
  input  logic       i_h0_ready,
  input  logic [7:0] i_h1_data,
  input  logic       i_h1_valid,
  output logic       o_h1_ready,
  output logic [7:0] o_h1_data,
  output logic       o_h1_valid,
  input  logic       i_h1_ready,
  output logic [7:0] o_tgt_data,
  output logic       o_tgt_valid,
  input  logic       i_tgt_ready,
  input  logic [7:0] i_tgt_data,
  input  logic       i_tgt_valid,
  output logic       o_tgt_ready,
  output logic       o_owner,
  output logic       o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WRDATA, S_RESP} state_t;

  state_t     r_state;
  logic       r_owner;   // current or most recent grant, 1 after reset so host0 wins the first tie
  logic [6:0] r_addr;    // address of the command in flight
  logic [7:0] r_burst;   // shadow of the target's burst count register
  logic [8:0] r_cnt;     // bytes/responses left in the current phase, 1..256

  logic [7:0] w_own_data;
  logic       w_own_valid;
  logic       w_own_rsp_rdy;
  logic       w_fwd;
  logic       w_resp;
  logic       w_fwd_acc;
  logic       w_rsp_acc;
  logic       w_pick;
  logic       w_addr_is_burst;
  logic [8:0] w_n;

  assign w_own_data    = r_owner ? i_h1_data  : i_h0_data;
  assign w_own_valid   = r_owner ? i_h1_valid : i_h0_valid;
  assign w_own_rsp_rdy = r_owner ? i_h1_ready : i_h0_ready;

  assign w_fwd  = (r_state == S_CMD) || (r_state == S_WRDATA);
  assign w_resp = (r_state == S_RESP);

  // Request path: only the owner sees target ready, and only while commands/data flow
  assign o_tgt_valid = w_fwd & w_own_valid;
  assign o_tgt_data  = w_fwd ? w_own_data : 8'h00;
  assign o_h0_ready  = w_fwd & ~r_owner & i_tgt_ready;
  assign o_h1_ready  = w_fwd &  r_owner & i_tgt_ready;

  // Response path: target responses outside RESP stay pending at the target
  assign o_tgt_ready = w_resp & w_own_rsp_rdy;
  assign o_h0_valid  = w_resp & ~r_owner & i_tgt_valid;
  assign o_h1_valid  = w_resp &  r_owner & i_tgt_valid;
  assign o_h0_data   = (w_resp & ~r_owner) ? i_tgt_data : 8'h00;
  assign o_h1_data   = (w_resp &  r_owner) ? i_tgt_data : 8'h00;

  assign w_fwd_acc = o_tgt_valid & i_tgt_ready;
  assign w_rsp_acc = i_tgt_valid & o_tgt_ready;

  // Transfer length of the command being accepted; a pending burst applies to any non-burst address
  assign w_n = ((w_own_data[6:0] != BURST_ADDR) && (r_burst != 8'd0)) ?
               ({1'b0, r_burst} + 9'd1) : 9'd1;

  assign w_addr_is_burst = (r_addr == BURST_ADDR);

  // Round-robin on a tie when FAIR, otherwise host0 always wins
  assign w_pick = FAIR ? ((i_h0_valid & i_h1_valid) ? ~r_owner : i_h1_valid)
                       : ~i_h0_valid;

  assign o_owner = r_owner;
  assign o_busy  = (r_state != S_IDLE);

  // Transaction FSM: grant, command, write data, responses; burst setup keeps the grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b1;
      r_addr  <= 7'd0;
      r_burst <= 8'd0;
      r_cnt   <= 9'd0;
    end else if (i_cg) begin
      case (r_state)
        S_IDLE: begin
          if (i_h0_valid | i_h1_valid) begin
            r_owner <= w_pick;
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_fwd_acc) begin
            r_addr  <= w_own_data[6:0];
            r_cnt   <= w_n;
            r_state <= w_own_data[7] ? S_WRDATA : S_RESP;
          end
        end
        S_WRDATA: begin
          if (w_fwd_acc) begin
            if (w_addr_is_burst) begin
              r_burst <= w_own_data;
            end
            if (r_cnt == 9'd1) begin
              r_state <= S_RESP;
              r_cnt   <= 9'd1;
            end else begin
              r_cnt <= r_cnt - 9'd1;
            end
          end
        end
        S_RESP: begin
          if (w_rsp_acc) begin
            r_cnt <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              if (w_addr_is_burst && (r_burst != 8'd0)) begin
                r_state <= S_CMD;
              end else begin
                r_burst <= 8'd0;
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
